fifo_ram_ctrl: RTL
==================

Name: fifo_ram_ctrl

Overview:
- FIFO front-end that sits directly upstream of the single-port 8-bit ram block.
- Turns a valid/ready push stream and a pop request stream into ram wr/rd/address/data_in cycles, and returns ram data_out as popped data.
- Owns the read/write pointers, occupancy count and read/write arbitration, because the ram has only one address port.

Parameters:
- DATA_W, 8, width of data words; matches ram data_in/data_out.
- ADDR_W, 8, ram address width; FIFO depth = 2**ADDR_W = 256.

Ports:
- clk  input  1  rising-edge clock shared with the ram.
- rst  input  1  synchronous, active-high reset.
- push_valid  input  1  producer has a word on push_data.
- push_data  input  DATA_W  word to enqueue.
- push_ready  output  1  word accepted this cycle when push_valid & push_ready.
- pop_req  input  1  consumer requests one word.
- pop_ready  output  1  pop accepted this cycle when pop_req & pop_ready.
- pop_valid  output  1  pop_data valid; one-cycle pulse per accepted pop.
- pop_data  output  DATA_W  dequeued word; wired to ram_data_out.
- empty  output  1  count == 0.
- full  output  1  count == 2**ADDR_W.
- count  output  ADDR_W+1  current occupancy, 0..256.
- underflow  output  1  sticky; set by pop_req while empty.
- ram_wr  output  1  to ram wr.
- ram_rd  output  1  to ram rd.
- ram_address  output  ADDR_W  to ram address.
- ram_data_in  output  DATA_W  to ram data_in.
- ram_data_out  input  DATA_W  from ram data_out.

Behaviour:
- RAM contract:
  - At a clk rising edge with wr=1, the ram writes mem[address] <= data_in.
  - At a clk rising edge with rd=1, the ram registers mem[address] onto data_out.
  - Read latency is therefore 1 cycle.
  - wr and rd are never both 1 in the same cycle.
- Reset (synchronous, rst=1 at an edge):
  - wr_ptr=0, rd_ptr=0, count=0, pop_valid=0, underflow=0, last_grant=READ.
  - Outputs after reset: empty=1, full=0.
  - ram contents are not cleared.
  - Reset mid-read: pop_valid is 0 in the cycle after reset, even if a read was in flight.
- Request qualification (combinational):
  - want_w = push_valid & !full.
  - want_r = pop_req & !empty.
- Arbitration:
  - Only one of want_w / want_r: that request is granted.
  - Both: grant the opposite of last_grant, i.e. round-robin.
  - last_grant updates only on a granted cycle.
  - Never starve: under continuous contention, grants alternate W,R,W,R.
- Handshake:
  - push_ready = grant_w.
  - pop_ready = grant_r.
  - Both are combinational from the current inputs and state.
- Write cycle: ram_wr=1, ram_address=wr_ptr, ram_data_in=push_data; at the edge, wr_ptr+1 and count+1.
- Read cycle: ram_rd=1, ram_address=rd_ptr; at the edge, rd_ptr+1 and count-1; pop_valid=1 in the next cycle with pop_data=ram_data_out.
- Idle: ram_wr=ram_rd=0, ram_address=rd_ptr, ram_data_in=push_data.
- Pointers are ADDR_W wide and wrap modulo 256 (255 -> 0) with no special case.
- count changes by at most ±1 per cycle; never below 0 or above 256.
- Full:
  - push_ready=0 regardless of arbitration.
  - A pop in the full state is granted and full deasserts the next cycle.
- Empty:
  - pop_ready=0.
  - pop_req while empty sets underflow (sticky until rst); no ram access, no pointer change.
  - A simultaneous push is granted.
- Read-after-write: a pop granted in the cycle after a push to the same address returns the newly written word, because the ram write completed at the previous edge.
- Throughput:
  - 1 word/cycle when only one direction is active.
  - 0.5 word/cycle per direction under full contention.

Decomposition:
- Package fifo_ram_pkg:
  - DATA_W/ADDR_W defaults.
  - DEPTH = 2**ADDR_W.
  - grant encoding constants GRANT_W=1'b0, GRANT_R=1'b1.
- One sub-module, fifo_ram_arb: 2-way round-robin arbiter.
  - Inputs: clk, rst, want_w, want_r.
  - Outputs: grant_w, grant_r.
  - Holds last_grant.
- Pointers, count, flags and pop_valid live in fifo_ram_ctrl.

Test Plan:
- rst for 2 cycles -> count=0, empty=1, full=0, pop_valid=0, ram_wr=ram_rd=0, underflow=0.
- Push 8'hD7 then pop -> write at ram_address 8'h00; one cycle later ram_rd=1 at 8'h00; next cycle pop_valid=1, pop_data=8'hD7, count back to 0.
- Push 256 words 8'h00..8'hFF -> full=1 at count=256, push_ready=0 on the 257th push; then 256 pops return 8'h00..8'hFF in order with pointers wrapped to 0.
- Preload 4 words, hold push_valid and pop_req high for 8 cycles -> grants alternate, starting with the opposite of last_grant; 4 writes and 4 reads; count=4 at end.
- pop_req while empty together with push 8'h3C -> push granted, no read, underflow=1 and stays 1 until rst.
- Assert rst in the cycle after a granted read -> pop_valid=0 next cycle, count=0, empty=1.

Source files
------------

// File: rtl/fifo_ram_pkg.sv
// Shared widths and grant encoding for the single-port-RAM FIFO front-end.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fifo_ram_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    // Encoding of the arbiter's remembered winner.
    localparam logic GRANT_W = 1'b0;
    localparam logic GRANT_R = 1'b1;

endpackage

// File: rtl/fifo_ram_arb.sv
// Two-way round-robin arbiter between FIFO write and read requests.
// Latency: grants are combinational; last winner is registered.
// Backpressure: a losing request simply sees no grant and wins next contended cycle.
module fifo_ram_arb
    import fifo_ram_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic want_w,
    input  logic want_r,
    output logic grant_w,
    output logic grant_r
);

    logic last_grant;

    // Lone requester wins; on contention the side that did not win last time wins.
    always_comb begin
        grant_w = want_w & (!want_r | (last_grant == GRANT_R));
        grant_r = want_r & (!want_w | (last_grant == GRANT_W));
    end

    // Remember the winner only on cycles that actually granted something.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_R;
        end else if (grant_w) begin
            last_grant <= GRANT_W;
        end else if (grant_r) begin
            last_grant <= GRANT_R;
        end
    end

endmodule

// File: rtl/fifo_ram_ctrl.sv
// FIFO controller driving a single-port RAM: pointers, occupancy, flags, arbitration.
// Latency: push written at the accepting edge; popped data valid one cycle after pop accept.
// Backpressure: push_ready/pop_ready are combinational grants; full blocks pushes, empty blocks pops.
module fifo_ram_ctrl
    import fifo_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop_req,
    output logic              pop_ready,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              underflow,
    output logic              ram_wr,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    // Occupancy value meaning "every RAM location holds a word".
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              want_w;
    logic              want_r;
    logic              grant_w;
    logic              grant_r;

    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign want_w = push_valid & !full;
    assign want_r = pop_req & !empty;

    fifo_ram_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .want_w  (want_w),
        .want_r  (want_r),
        .grant_w (grant_w),
        .grant_r (grant_r)
    );

    assign push_ready = grant_w;
    assign pop_ready  = grant_r;
    // RAM registers its output, so the returned word is aligned with pop_valid.
    assign pop_data   = ram_data_out;

    // One RAM port: the address follows the write pointer only on a write cycle.
    always_comb begin
        ram_wr      = grant_w;
        ram_rd      = grant_r;
        ram_data_in = push_data;
        ram_address = grant_w ? wr_ptr : rd_ptr;
    end

    // Pointer, occupancy, pop strobe and sticky underflow bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (grant_w) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (grant_r) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            // Grants are exclusive, so occupancy moves by at most one.
            if (grant_w) begin
                count <= count + (ADDR_W + 1)'(1);
            end else if (grant_r) begin
                count <= count - (ADDR_W + 1)'(1);
            end
            pop_valid <= grant_r;
            if (pop_req && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
